apb_reg_slave: RTL and testbench
================================

// Module: apb_reg_slave
// PURPOSE
//  APB3 completer; sits directly downstream of the APB master and terminates its transfers.
//  Holds a bank of word-aligned 32-bit registers and a read-only count of completed transfers.
//  Drives PREADY (optional wait states), PRDATA and PSLVERR back to the master.
// PARAMETERS
//  DATA_W      32  data width; PWDATA, PRDATA and registers
//  NUM_REGS    8   register count, power of 2, >=2; reg[NUM_REGS-1] is the RO transfer counter
//  WAIT_CYCLES 2   PREADY-low cycles per access phase, used only with APB_REG_WAIT_EN (0..15)
// PORTS
//  PCLK     in   1       APB clock; all state updates on rising edge
//  PRESETn  in   1       asynchronous, active-low reset
//  PSEL     in   1       select from master
//  PENABLE  in   1       access-phase strobe
//  PWRITE   in   1       1=write, 0=read
//  PADDR    in   32      byte address
//  PWDATA   in   DATA_W  write data
//  PRDATA   out  DATA_W  read data; valid only when PREADY=1 in the access phase
//  PREADY   out  1       transfer-completion strobe
//  PSLVERR  out  1       error; valid only when PREADY=1 in the access phase
// BEHAVIOUR
//  Reset: state=IDLE; wait_cnt=0; all regs=0; xfer_cnt=0; PREADY=0, PRDATA=0, PSLVERR=0.
//  Decode: idx=PADDR[2 +: log2(NUM_REGS)].
//   err = (PADDR[1:0]!=0) | (PADDR >= 4*NUM_REGS) | (PWRITE & idx==NUM_REGS-1).
//  FSM, two states:
//   IDLE:   PSEL & !PENABLE at edge -> ACCESS; wait_cnt <= WAIT_CYCLES (0 without macro).
//           All other inputs stay in IDLE. PREADY=0.
//   ACCESS: PREADY = (wait_cnt==0), combinational.
//           wait_cnt!=0 -> decrement by 1 each cycle.
//           PSEL & PENABLE & PREADY at edge -> complete the transfer, go to IDLE:
//            - write, no err: reg[idx] <= PWDATA.
//            - every completion (err or not): xfer_cnt <= xfer_cnt+1, wraps 2^DATA_W-1 -> 0.
//           PSEL=0 in ACCESS (master abort) -> IDLE; no write; no count.
//  Outputs:
//   PRDATA = reg[idx] (or xfer_cnt) when PREADY & !PWRITE & !err; otherwise 0.
//   PSLVERR = err when PREADY; otherwise 0.
//  Error transfers never modify any register other than xfer_cnt.
//  Back-to-back: completion edge returns to IDLE; the master's next SETUP is accepted on the
//   following edge, so each transfer takes a minimum of 2 cycles.
//  Reset asserted mid-transfer: immediate return to reset values; the transfer is lost.
//  Read of reg[NUM_REGS-1] returns xfer_cnt before the current transfer is counted.
// CONFIGURATION
//  APB_REG_WAIT_EN defined: WAIT_CYCLES PREADY-low cycles per access (access phase =
//   WAIT_CYCLES+1 cycles).
//  APB_REG_WAIT_EN undefined: wait_cnt is tied to 0; PREADY=1 in the first access cycle;
//   WAIT_CYCLES is ignored.
// TESTING
//  1. Write 0x1234 to PADDR 0x0, then read 0x0 -> PRDATA=0x1234, PSLVERR=0, PREADY=1 in the
//     first access cycle (macro off).
//  2. Macro on, WAIT_CYCLES=2: write 0xA5A5_0001 to 0x8 -> PREADY low for 2 access cycles,
//     high on the 3rd; readback 0xA5A50001.
//  3. Write to 0x1C (RO counter) and 0x20 (out of range) and 0x5 (unaligned) -> PSLVERR=1,
//     regs unchanged, PRDATA=0.
//  4. After 5 completed transfers, read 0x1C -> PRDATA=5; the count is 6 after that read.
//  5. PSEL dropped mid-wait (macro on) -> FSM returns to IDLE, no write, counter unchanged.
//  6. PRESETn pulsed low during ACCESS after writing 0x1234 to 0x0 -> read 0x0 returns 0,
//     PREADY/PSLVERR=0 while in reset.

Source files
------------

// File: rtl/apb_reg_slave_if.sv
// APB3 bus bundle between a master and apb_reg_slave.
// Carries the request (psel, penable, pwrite, paddr, pwdata) and the response
// (prdata, pready, pslverr). PCLK and PRESETn are not part of the bundle.
// Modports: master drives the request; slave drives the response.
interface apb_reg_slave_if #(
    parameter int unsigned DATA_W = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [31:0]       paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_reg_slave.sv
// APB3 completer with a bank of word-aligned registers.
// reg[NUM_REGS-1] is a read-only count of completed transfers (error transfers included).
// Ports:
//   PCLK    - APB clock, rising edge
//   PRESETn - asynchronous active-low reset
//   apb_io  - apb_reg_slave_if.slave bus (psel/penable/pwrite/paddr/pwdata in,
//             prdata/pready/pslverr out)
// Build option: define APB_REG_WAIT_EN to insert WAIT_CYCLES PREADY-low cycles in each
// access phase; without it PREADY is high in the first access cycle.
module apb_reg_slave #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic            PCLK,
    input logic            PRESETn,
    apb_reg_slave_if.slave apb_io
);
    localparam int unsigned     IdxW      = $clog2(NUM_REGS);
    localparam logic [IdxW-1:0] CntIdx    = IdxW'(NUM_REGS - 1);
    localparam logic [31:0]     AddrLimit = 32'(4 * NUM_REGS);

    if (WAIT_CYCLES > 15 || NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0)
    begin : g_param_check
        $error("apb_reg_slave: WAIT_CYCLES must be 0..15, NUM_REGS a power of 2 >= 2");
    end

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS-1];
    logic [DATA_W-1:0] regs_d [NUM_REGS-1];
    logic [DATA_W-1:0] xfer_cnt_q, xfer_cnt_d;
    logic [3:0]        wait_cnt;
    logic [IdxW-1:0]   idx;
    logic              err;
    logic              pready;
    logic              complete;
    logic              setup;
    logic [DATA_W-1:0] rdata;

    assign idx   = apb_io.paddr[2 +: IdxW];
    assign err   = (apb_io.paddr[1:0] != 2'b00) | (apb_io.paddr >= AddrLimit) |
                   (apb_io.pwrite & (idx == CntIdx));
    assign setup = (state_q == StIdle) & apb_io.psel & ~apb_io.penable;

`ifdef APB_REG_WAIT_EN
    logic [3:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (setup) begin
            wait_cnt_d = 4'(WAIT_CYCLES);
        end else if (state_q == StAccess && wait_cnt_q != 4'd0) begin
            wait_cnt_d = wait_cnt_q - 4'd1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt_q <= 4'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign wait_cnt = wait_cnt_q;
`else
    assign wait_cnt = 4'd0;
`endif

    assign pready = (state_q == StAccess) & (wait_cnt == 4'd0);

    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (setup) state_d = StAccess;
            end
            StAccess: begin
                if (!apb_io.psel) begin
                    // Master abort: drop the transfer without writing or counting.
                    state_d = StIdle;
                end else if (apb_io.penable && pready) begin
                    state_d  = StIdle;
                    complete = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        xfer_cnt_d = complete ? xfer_cnt_q + DATA_W'(1) : xfer_cnt_q;
        for (int i = 0; i < int'(NUM_REGS) - 1; i++) begin
            regs_d[i] = regs_q[i];
            if (complete && apb_io.pwrite && !err && idx == IdxW'(i)) begin
                regs_d[i] = apb_io.pwdata;
            end
        end
    end

    // Counter slot reads the pre-increment value of the transfer in flight.
    always_comb begin
        rdata = xfer_cnt_q;
        for (int i = 0; i < int'(NUM_REGS) - 1; i++) begin
            if (idx == IdxW'(i)) rdata = regs_q[i];
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= StIdle;
            xfer_cnt_q <= '0;
            for (int i = 0; i < int'(NUM_REGS) - 1; i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            xfer_cnt_q <= xfer_cnt_d;
            for (int i = 0; i < int'(NUM_REGS) - 1; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign apb_io.pready  = pready;
    assign apb_io.pslverr = pready & err;
    assign apb_io.prdata  = (pready & ~apb_io.pwrite & ~err) ? rdata : '0;
endmodule

// File: tb/tb_apb_reg_slave.sv
module tb_apb_reg_slave;
    localparam int unsigned DataW = 32;
`ifdef APB_REG_WAIT_EN
    localparam int unsigned WaitExp = 2;
`else
    localparam int unsigned WaitExp = 0;
`endif

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned waits;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb_q[$];
    vec_t vecs[17];

    apb_reg_slave_if #(.DATA_W(DataW)) bus ();

    apb_reg_slave #(
        .DATA_W     (DataW),
        .NUM_REGS   (8),
        .WAIT_CYCLES(2)
    ) dut (
        .PCLK   (clk),
        .PRESETn(rst_n),
        .apb_io (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Call just after a rising edge; returns just after the completion edge.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_err);
        exp_t        e;
        int unsigned waits;
        logic        done;
        sb_q.push_back('{rdata: exp_rdata, err: exp_err, waits: WaitExp});
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = wdata;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        waits = 0;
        done  = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (bus.pready) done = 1'b1;
            else waits++;
        end
        e = sb_q.pop_front();
        if (!done) begin
            check("pready_timeout", 32'(done), 32'd1);
        end else begin
            check($sformatf("prdata@%0h", addr), bus.prdata, e.rdata);
            check($sformatf("pslverr@%0h", addr), 32'(bus.pslverr), 32'(e.err));
            check($sformatf("waits@%0h", addr), 32'(waits), 32'(e.waits));
        end
        @(posedge clk); #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // wr, addr, wdata, expected prdata, expected pslverr
        vecs[0]  = '{1'b1, 32'h00, 32'h0000_1234, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h00, 32'h0,         32'h0000_1234, 1'b0};
        vecs[2]  = '{1'b1, 32'h08, 32'hA5A5_0001, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 32'h08, 32'h0,         32'hA5A5_0001, 1'b0};
        vecs[4]  = '{1'b1, 32'h1C, 32'h0000_DEAD, 32'h0000_0000, 1'b1};
        vecs[5]  = '{1'b0, 32'h1C, 32'h0,         32'h0000_0005, 1'b0};
        vecs[6]  = '{1'b1, 32'h20, 32'h0000_BEEF, 32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b1, 32'h05, 32'h0000_CAFE, 32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b0, 32'h20, 32'h0,         32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b0, 32'h04, 32'h0,         32'h0000_0000, 1'b0};
        vecs[10] = '{1'b0, 32'h00, 32'h0,         32'h0000_1234, 1'b0};
        vecs[11] = '{1'b1, 32'h04, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[12] = '{1'b0, 32'h04, 32'h0,         32'hFFFF_FFFF, 1'b0};
        vecs[13] = '{1'b0, 32'h18, 32'h0,         32'h0000_0000, 1'b0};
        vecs[14] = '{1'b0, 32'h1C, 32'h0,         32'h0000_000E, 1'b0};
        vecs[15] = '{1'b0, 32'h06, 32'h0,         32'h0000_0000, 1'b1};
        vecs[16] = '{1'b0, 32'h1C, 32'h0,         32'h0000_0010, 1'b0};

        rst_n       = 1'b0;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = 32'h0;
        bus.pwdata  = 32'h0;
        #12;
        check("reset_pready", 32'(bus.pready), 32'd0);
        check("reset_pslverr", 32'(bus.pslverr), 32'd0);
        check("reset_prdata", bus.prdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_pready", 32'(bus.pready), 32'd0);

        // Back-to-back table transfers; counter reaches 17.
        for (int i = 0; i < 17; i++) begin
            apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err);
        end

        // Master abort: drop PSEL in the access phase (mid-wait when waits are enabled).
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b1;
        bus.paddr   = 32'h00;
        bus.pwdata  = 32'h5555_5555;
        @(posedge clk); #1;
        if (WaitExp > 0) begin
            bus.penable = 1'b1;
            @(posedge clk); #1;
        end
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        @(posedge clk); #1;
        check("abort_idle_pready", 32'(bus.pready), 32'd0);
        apb_xfer(1'b0, 32'h00, 32'h0, 32'h0000_1234, 1'b0);
        apb_xfer(1'b0, 32'h1C, 32'h0, 32'h0000_0012, 1'b0);

        // Reset pulsed during an access phase.
        apb_xfer(1'b1, 32'h00, 32'h0000_1234, 32'h0, 1'b0);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = 32'h00;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_pready", 32'(bus.pready), 32'd0);
        check("midrst_pslverr", 32'(bus.pslverr), 32'd0);
        check("midrst_prdata", bus.prdata, 32'd0);
        @(posedge clk); #1;
        check("midrst_pready_held", 32'(bus.pready), 32'd0);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        apb_xfer(1'b0, 32'h00, 32'h0, 32'h0000_0000, 1'b0);
        apb_xfer(1'b0, 32'h1C, 32'h0, 32'h0000_0001, 1'b0);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
